// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package  : alu_pkg
// Purpose  : Shared opcode/func encodings of the alu instruction set, issue
//            FSM state encoding, error codes and flag bit positions.
// Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  // Opcodes understood by the alu
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type func codes understood by the alu
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Issue FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Error codes reported on out_err
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_OVF     = 2'b10;

  // Bit positions inside alu flags {zero,neg,overflow}
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_OVF  = 0;

endpackage
`default_nettype wire

// File: rtl/alu_wb_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_wb_decode
// Purpose  : Combinational decode of an executed instruction and its alu
//            flags into write-back enable/index, branch outcome and error.
// Ports    : instr    in  32  instruction being executed
//            flags    in  3   alu flags {zero,neg,overflow}
//            wb_en    out 1   write alu result into the register file
//            wb_idx   out IW  register file entry to write
//            br_taken out 1   beq/bne resolved as taken
//            err      out 2   00 ok, 01 illegal, 10 overflow trap
// Revision : 1.0  initial release
// ============================================================================
module alu_wb_decode
  import alu_pkg::*;
#(
  parameter int NREGS = 2,
  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic [31:0]   instr,
  input  logic [2:0]    flags,
  output logic          wb_en,
  output logic [IW-1:0] wb_idx,
  output logic          br_taken,
  output logic [1:0]    err
);

  // Register file depth expressed on the 5-bit register-field scale
  localparam logic [4:0] NREGS_L = 5'(NREGS);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] dest;
  logic       legal;
  logic       has_dest;
  logic       trap_op;
  logic       ovf_trap;

  // rs and shamt fields only matter to the alu itself
  logic unused_fields;
  assign unused_fields = ^{instr[25:21], instr[10:6], flags[FLAG_NEG]};

  assign op = instr[31:26];
  assign fn = instr[5:0];

  always_comb begin
    legal    = 1'b0;
    has_dest = 1'b0;
    trap_op  = 1'b0;
    dest     = 5'd0;
    br_taken = 1'b0;
    case (op)
      OP_RTYPE: begin
        has_dest = 1'b1;
        dest     = instr[15:11];
        case (fn)
          FN_ADD, FN_SUB: begin
            legal   = 1'b1;
            trap_op = 1'b1;
          end
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU: legal = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI: begin
        legal    = 1'b1;
        has_dest = 1'b1;
        trap_op  = 1'b1;
        dest     = instr[20:16];
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        legal    = 1'b1;
        has_dest = 1'b1;
        dest     = instr[20:16];
      end
      OP_BEQ: begin
        legal    = 1'b1;
        br_taken = flags[FLAG_ZERO];
      end
      OP_BNE: begin
        legal    = 1'b1;
        br_taken = ~flags[FLAG_ZERO];
      end
      // Memory ops: the alu result is only the effective address
      OP_LW, OP_SW: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign ovf_trap = legal & trap_op & flags[FLAG_OVF];
  assign err      = !legal ? ERR_ILLEGAL : (ovf_trap ? ERR_OVF : ERR_OK);
  // Destinations beyond the small register file are silently dropped
  assign wb_en    = legal & has_dest & ~ovf_trap & (dest < NREGS_L);
  assign wb_idx   = dest[IW-1:0];

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Sequential front/back end around the combinational alu. Accepts
//            one instruction per handshake, presents it with rf[0]/rf[1] to
//            the alu, captures the result, writes back, resolves branches and
//            returns one result beat per instruction.
// Ports    : clk, rst_n                 clock, synchronous active-low reset
//            in_valid/in_ready/in_instr instruction handshake
//            rf_we/rf_idx/rf_wdata      register preload (IDLE only)
//            alu_instr/alu_gr1/alu_gr2  operands to the alu
//            alu_c/alu_flags            result from the alu
//            out_valid/out_ready        result handshake
//            out_result/out_flags/out_br_taken/out_wb/out_err  result beat
// Revision : 1.0  initial release
// ============================================================================
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int W     = 32,
  parameter int NREGS = 2,
  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instr,
  input  logic          rf_we,
  input  logic [IW-1:0] rf_idx,
  input  logic [W-1:0]  rf_wdata,
  output logic [31:0]   alu_instr,
  output logic [W-1:0]  alu_gr1,
  output logic [W-1:0]  alu_gr2,
  input  logic [W-1:0]  alu_c,
  input  logic [2:0]    alu_flags,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_result,
  output logic [2:0]    out_flags,
  output logic          out_br_taken,
  output logic          out_wb,
  output logic [1:0]    out_err
);

  state_t        state;
  state_t        state_nx;
  logic [W-1:0]  rf [NREGS];
  logic          wb_en;
  logic [IW-1:0] wb_idx;
  logic          br_taken;
  logic [1:0]    err;

  // Decode works on the latched instruction and the settled alu flags
  alu_wb_decode #(.NREGS(NREGS)) u_decode (
    .instr    (alu_instr),
    .flags    (alu_flags),
    .wb_en    (wb_en),
    .wb_idx   (wb_idx),
    .br_taken (br_taken),
    .err      (err)
  );

  assign alu_gr1 = rf[0];
  assign alu_gr2 = rf[1];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_EXEC;
      end
      S_EXEC: state_nx = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Preload and write-back live in disjoint states, so one write port at a
  // time. A preload coinciding with an accept commits on the same edge and
  // is therefore visible to that instruction in EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      alu_instr    <= '0;
      out_result   <= '0;
      out_flags    <= '0;
      out_br_taken <= 1'b0;
      out_wb       <= 1'b0;
      out_err      <= ERR_OK;
    end else begin
      case (state)
        S_IDLE: begin
          if (rf_we)    rf[rf_idx] <= rf_wdata;
          if (in_valid) alu_instr  <= in_instr;
        end
        S_EXEC: begin
          out_result   <= alu_c;
          out_flags    <= alu_flags;
          out_br_taken <= br_taken;
          out_wb       <= wb_en;
          out_err      <= err;
          if (wb_en) rf[wb_idx] <= alu_c;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Purpose  : Bench for alu_issue_ctrl with a behavioural alu next to it and a
//            queue-based scoreboard fed by a register-file reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_ctrl;

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  fl;
    logic        br;
    logic        wb;
    logic [1:0]  err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic        rf_we = 1'b0;
  logic [0:0]  rf_idx = '0;
  logic [31:0] rf_wdata = '0;
  logic [31:0] alu_instr, alu_gr1, alu_gr2, alu_c;
  logic [2:0]  alu_flags;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [2:0]  out_flags;
  logic        out_br_taken, out_wb;
  logic [1:0]  out_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mrf [2];
  exp_t        expq [$];
  bit          rand_ready = 1'b0;

  logic [5:0]  fntab [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                              6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  logic [5:0]  optab [11] = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                              6'h0E, 6'h23, 6'h2B};

  always #5 clk = ~clk;

  alu_issue_ctrl #(.W(32), .NREGS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .rf_we(rf_we), .rf_idx(rf_idx), .rf_wdata(rf_wdata),
    .alu_instr(alu_instr), .alu_gr1(alu_gr1), .alu_gr2(alu_gr2),
    .alu_c(alu_c), .alu_flags(alu_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .out_br_taken(out_br_taken), .out_wb(out_wb), .out_err(out_err)
  );

  // Behavioural MIPS alu: returns {zero,neg,overflow,c}
  function automatic logic [34:0] alu_model(input logic [31:0] ins,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [31:0] c, se, ze;
    logic        ov;
    logic [4:0]  sh;
    sh = ins[10:6];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'd0, ins[15:0]};
    c  = '0;
    ov = 1'b0;
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h00: c = b << sh;
        6'h02: c = b >> sh;
        6'h03: c = $signed(b) >>> sh;
        6'h04: c = b << a[4:0];
        6'h06: c = b >> a[4:0];
        6'h07: c = $signed(b) >>> a[4:0];
        6'h20: begin c = a + b; ov = (a[31] == b[31]) && (c[31] != a[31]); end
        6'h21: c = a + b;
        6'h22: begin c = a - b; ov = (a[31] != b[31]) && (c[31] != a[31]); end
        6'h23: c = a - b;
        6'h24: c = a & b;
        6'h25: c = a | b;
        6'h26: c = a ^ b;
        6'h27: c = ~(a | b);
        6'h2A: c = {31'd0, $signed(a) < $signed(b)};
        6'h2B: c = {31'd0, a < b};
        default: c = '0;
      endcase
      6'h08: begin c = a + se; ov = (a[31] == se[31]) && (c[31] != a[31]); end
      6'h09: c = a + se;
      6'h0A: c = {31'd0, $signed(a) < $signed(se)};
      6'h0B: c = {31'd0, a < se};
      6'h0C: c = a & ze;
      6'h0D: c = a | ze;
      6'h0E: c = a ^ ze;
      6'h04, 6'h05: c = a - b;
      6'h23, 6'h2B: c = a + se;
      default: c = '0;
    endcase
    return {c == 32'd0, c[31], ov, c};
  endfunction

  assign {alu_flags, alu_c} = alu_model(alu_instr, alu_gr1, alu_gr2);

  function automatic bit is_legal(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'h00)
      return fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, [6'h20:6'h27], 6'h2A, 6'h2B};
    return op inside {6'h04, 6'h05, [6'h08:6'h0E], 6'h23, 6'h2B};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: predicts the result beat and updates the model register file
  task automatic model_issue(input logic [31:0] ins);
    logic [34:0] r;
    exp_t        e;
    logic [5:0]  op, fn;
    int          dest;
    bit          legal, trap;
    op    = ins[31:26];
    fn    = ins[5:0];
    r     = alu_model(ins, mrf[0], mrf[1]);
    e.res = r[31:0];
    e.fl  = r[34:32];
    legal = is_legal(ins);
    if (op == 6'h00)                  dest = int'(ins[15:11]);
    else if (op inside {[6'h08:6'h0E]}) dest = int'(ins[20:16]);
    else                              dest = -1;
    trap  = legal && e.fl[0] && ((op == 6'h00 && fn inside {6'h20, 6'h22}) || op == 6'h08);
    e.err = !legal ? 2'b01 : (trap ? 2'b10 : 2'b00);
    e.br  = (op == 6'h04 && e.fl[2]) || (op == 6'h05 && !e.fl[2]);
    e.wb  = legal && !trap && dest >= 0 && dest < 2;
    if (e.wb) mrf[dest] = e.res;
    expq.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: in_ready=%0b required 1", name, in_ready);
    end
  endtask

  task automatic preload(input bit idx, input logic [31:0] wd);
    wait_idle("preload");
    rf_we = 1'b1; rf_idx = idx; rf_wdata = wd;
    mrf[idx] = wd;
    @(posedge clk); #1;
    rf_we = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins, input bit we, input bit idx, input logic [31:0] wd);
    wait_idle("issue");
    check("rf0_before_issue", 64'(alu_gr1), 64'(mrf[0]));
    check("rf1_before_issue", 64'(alu_gr2), 64'(mrf[1]));
    in_valid = 1'b1; in_instr = ins;
    rf_we = we; rf_idx = idx; rf_wdata = wd;
    if (we) mrf[idx] = wd;
    model_issue(ins);
    @(posedge clk); #1;
    in_valid = 1'b0; rf_we = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    int          k;
    logic [5:0]  op, fn;
    logic [15:0] imm;
    k   = $urandom_range(0, 19);
    imm = ($urandom_range(0, 3) == 0) ? 16'h0001 : 16'($urandom);
    if (k < 8) begin
      op = 6'h00;
      fn = (k == 7) ? 6'($urandom) : fntab[$urandom_range(0, 15)];
      return {op, 5'($urandom_range(0, 1)), 5'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), 5'($urandom), fn};
    end
    op = (k < 19) ? optab[$urandom_range(0, 10)] : 6'($urandom);
    return {op, 5'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), imm};
  endfunction

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Consumer-side backpressure
  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: stability while stalled, and scoreboard compare on each handshake
  initial begin
    logic [63:0] snap;
    logic [63:0] cur;
    bit          have_snap;
    exp_t        e;
    have_snap = 1'b0;
    snap      = '0;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        cur = {25'd0, out_result, out_flags, out_br_taken, out_wb, out_err};
        check("in_ready_while_done", 64'(in_ready), 64'd0);
        if (have_snap) check("done_stable", cur, snap);
        if (out_ready) begin
          if (expq.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_beat: got result 0x%0h expected no beat", out_result);
          end else begin
            e = expq.pop_front();
            check("out_result", 64'(out_result), 64'(e.res));
            check("out_flags", 64'(out_flags), 64'(e.fl));
            check("out_br_taken", 64'(out_br_taken), 64'(e.br));
            check("out_wb", 64'(out_wb), 64'(e.wb));
            check("out_err", 64'(out_err), 64'(e.err));
          end
          have_snap = 1'b0;
        end else begin
          snap      = cur;
          have_snap = 1'b1;
        end
      end else begin
        have_snap = 1'b0;
      end
    end
  end

  initial begin
    int n;
    mrf[0] = '0;
    mrf[1] = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_alu_instr", 64'(alu_instr), 64'd0);
    check("reset_rf0", 64'(alu_gr1), 64'd0);
    check("reset_rf1", 64'(alu_gr2), 64'd0);
    check("reset_outs", {25'd0, out_result, out_flags, out_br_taken, out_wb, out_err}, 64'd0);

    // add r1 = r0 + r1, rf1 preloaded in the accept cycle
    preload(1'b0, 32'd5);
    issue(32'h0001_0820, 1'b1, 1'b1, 32'd7);
    wait_idle("t1");
    check("add_writeback_rf1", 64'(alu_gr2), 64'd12);

    // addi overflow trap leaves rf0 untouched
    preload(1'b0, 32'h7FFF_FFFF);
    issue(32'h2000_0001, 1'b0, 1'b0, 32'd0);
    wait_idle("t2");
    check("addi_trap_rf0_kept", 64'(alu_gr1), 64'h7FFF_FFFF);

    // beq / bne with equal operands
    preload(1'b0, 32'd9);
    preload(1'b1, 32'd9);
    issue(32'h1001_0000, 1'b0, 1'b0, 32'd0);
    issue(32'h1401_0000, 1'b0, 1'b0, 32'd0);

    // illegal opcode
    issue(32'hFC00_0000, 1'b0, 1'b0, 32'd0);
    wait_idle("t4");
    check("illegal_back_to_idle", 64'(in_ready), 64'd1);

    // stall in DONE for three cycles
    out_ready = 1'b0;
    issue(32'h0001_0820, 1'b0, 1'b0, 32'd0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    check("stall_reached_done", 64'(out_valid), 64'd1);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle("t5");

    // reset during EXEC aborts the instruction
    issue(32'h0001_0820, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mrf[0] = '0;
    mrf[1] = '0;
    expq.delete();
    @(negedge clk);
    check("abort_rf0", 64'(alu_gr1), 64'd0);
    check("abort_rf1", 64'(alu_gr2), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);

    // randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) preload(1'($urandom_range(0, 1)), rand_data());
      issue(rand_instr(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_data());
    end

    n = 0;
    while (expq.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (expq.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: %0d beats outstanding, required 0", expq.size());
    end
    wait_idle("final");
    check("final_rf0", 64'(alu_gr1), 64'(mrf[0]));
    check("final_rf1", 64'(alu_gr2), 64'(mrf[1]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
